// File: rtl/risc_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : risc_run_controller
// Brief    : Run/step/halt sequencer for a RISC core with breakpoint, cycle
//            limit and external halt, plus a saturating retired-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module risc_run_controller #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             step,
    input  logic             clear,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic [31:0]      pc,
    input  logic             halt_instr,
    output logic             core_en,
    output logic             core_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic [2:0]       cause
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] c_CAUSE_NONE  = 3'd0;
    localparam logic [2:0] c_CAUSE_HALT  = 3'd1;
    localparam logic [2:0] c_CAUSE_BP    = 3'd2;
    localparam logic [2:0] c_CAUSE_LIMIT = 3'd3;
    localparam logic [2:0] c_CAUSE_HREQ  = 3'd4;
    localparam logic [2:0] c_CAUSE_STEP  = 3'd5;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_cause;
    logic [2:0]       w_cause_nxt;
    logic             r_bp_skip;
    logic             w_skip_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_stop_hi;
    logic             w_stop_bp;
    logic             w_stop_lim;
    logic             w_stop;
    logic [2:0]       w_stop_cause;
    logic             w_core_en;

    // Stop conditions only matter in RUN; the priority chain picks the cause.
    always_comb begin
        w_stop_hi    = halt_instr;
        w_stop_bp    = bp_en && (pc == bp_addr) && !r_bp_skip;
        w_stop_lim   = (max_cycles != '0) && (r_cnt >= max_cycles);
        w_stop       = w_stop_hi || w_stop_bp || w_stop_lim || halt_req;
        w_stop_cause = c_CAUSE_NONE;
        if (w_stop_hi) begin
            w_stop_cause = c_CAUSE_HALT;
        end else if (w_stop_bp) begin
            w_stop_cause = c_CAUSE_BP;
        end else if (w_stop_lim) begin
            w_stop_cause = c_CAUSE_LIMIT;
        end else if (halt_req) begin
            w_stop_cause = c_CAUSE_HREQ;
        end
    end

    always_comb begin
        w_core_en   = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        w_skip_nxt  = r_bp_skip;

        case (r_state)
            ST_RUN:  w_core_en = !w_stop;
            ST_STEP: w_core_en = 1'b1;
            default: w_core_en = 1'b0;
        endcase

        if (w_core_en && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_cause_nxt = c_CAUSE_NONE;
                        w_skip_nxt  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_stop) begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = w_stop_cause;
                    end else begin
                        // First executed cycle after a resume moves past the breakpoint.
                        w_skip_nxt  = 1'b0;
                    end
                end
                ST_STEP: begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = c_CAUSE_STEP;
                end
                default: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_skip_nxt  = 1'b1;
                    end else if (step) begin
                        w_state_nxt = ST_STEP;
                    end
                end
            endcase
        end

        w_done_nxt = (w_state_nxt == ST_HALTED) && (r_state != ST_HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cause   <= c_CAUSE_NONE;
            r_bp_skip <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cause   <= w_cause_nxt;
            r_bp_skip <= w_skip_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign core_en     = w_core_en;
    assign core_rst    = (r_state == ST_IDLE);
    assign state       = r_state;
    assign cycle_count = r_cnt;
    assign done        = r_done;
    assign cause       = r_cause;

endmodule
`default_nettype wire

// File: doc/risc_run_controller.md
RISC_RUN_CONTROLLER -- requirements
Module: risc_run_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning the width of the retired-cycle counter and the cycle limit.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1: from IDLE, begin a run; from HALTED, resume.
REQ-005 The block SHALL have port step, input, 1: from HALTED, execute exactly one core cycle.
REQ-006 The block SHALL have port clear, input, 1: abort and return to IDLE from any state.
REQ-007 The block SHALL have port halt_req, input, 1: external stop request.
REQ-008 The block SHALL have port bp_en, input, 1: breakpoint enable.
REQ-009 The block SHALL have port bp_addr, input, 32: breakpoint PC.
REQ-010 The block SHALL have port max_cycles, input, CNT_W: run cycle limit; 0 means unlimited.
REQ-011 The block SHALL have port pc, input, 32: the core's current PC.
REQ-012 The block SHALL have port halt_instr, input, 1: the core decodes a halt opcode at pc.
REQ-013 The block SHALL have port core_en, output, 1: the core's state-update enable.
REQ-014 The block SHALL have port core_rst, output, 1: held reset to the core.
REQ-015 The block SHALL have port state, output, 2: IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-016 The block SHALL have port cycle_count, output, CNT_W: cycles with core_en=1 since the run began.
REQ-017 The block SHALL have port done, output, 1: one-cycle pulse on entry to HALTED.
REQ-018 The block SHALL have port cause, output, 3: 0 none, 1 halt_instr, 2 breakpoint, 3 cycle limit, 4 halt_req, 5 step.

Function
REQ-019 core_rst SHALL be 1 exactly when state=IDLE.
REQ-020 core_en SHALL be combinational: 0 in IDLE and HALTED; 1 in STEP; 1 in RUN unless a stop condition is true in that cycle.
REQ-021 cycle_count SHALL increment by 1 on each edge where core_en=1, saturating at all-ones.
REQ-022 RUN stop conditions, in priority order, SHALL be: halt_instr=1; then bp_en=1 and pc==bp_addr and bp_skip=0; then max_cycles!=0 and cycle_count>=max_cycles; then halt_req=1.
REQ-023 On a stop, the instruction at pc SHALL NOT execute (core_en=0); the next state SHALL be HALTED, cause SHALL latch the highest-priority condition, and done SHALL pulse the following cycle.
REQ-024 IDLE with start=1 SHALL go to RUN, clear cycle_count to 0, set cause to 0 and set bp_skip to 0; step in IDLE SHALL be ignored.
REQ-025 HALTED with start=1 SHALL go to RUN and set bp_skip to 1; start SHALL take priority over step.
REQ-026 HALTED with step=1 (start=0) SHALL go to STEP; STEP SHALL last exactly one cycle, then go to HALTED with cause=5 and done pulsing, whatever the stop conditions.
REQ-027 bp_skip SHALL clear after the first RUN cycle with core_en=1, so a run resumed at the breakpoint PC moves past it.
REQ-028 clear=1 SHALL force IDLE on the next edge from any state, overriding start and step; cycle_count and cause SHALL hold their values until the next start.
REQ-029 Simultaneous halt_req and start while in HALTED SHALL resolve to start; halt_req is evaluated only in RUN.
REQ-030 done SHALL be registered, high for exactly one cycle per HALTED entry, and never asserted in the same cycle as core_en=1.

Reset
REQ-031 With RST=1 at an edge, the next state SHALL be IDLE, with cycle_count=0, cause=0, done=0 and bp_skip=0; RST SHALL override clear, start and step.
REQ-032 While RST=1 or immediately after reset, outputs SHALL be core_rst=1 and core_en=0; RST asserted mid-RUN SHALL return the block to IDLE on that edge.

Verification
REQ-033 Limit run: max_cycles=5, start -> exactly 5 cycles with core_en=1, then HALTED, cause=3, cycle_count=5, done pulses once.
REQ-034 Breakpoint then resume: bp_en=1, bp_addr=0x10, pc reaches 0x10 -> core_en=0 that cycle, cause=2; start -> core_en=1 at pc=0x10 with no re-trigger.
REQ-035 Priority: halt_instr=1, pc==bp_addr, halt_req=1 in the same RUN cycle -> cause=1.
REQ-036 Single step: from HALTED, one-cycle step pulse -> STEP for 1 cycle, cycle_count +1, cause=5, done pulses.
REQ-037 Abort: clear mid-RUN -> IDLE next cycle, core_rst=1, cycle_count held; a following start -> cycle_count=0.
REQ-038 Reset mid-run: RST=1 during RUN with max_cycles=0 -> IDLE, all outputs at reset values, no done pulse.
